// File: rtl/serial_read_buffer_pkg.sv
// Shared types and constants for the serial read buffer.
`timescale 1ns/1ps
package serial_read_buffer_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

endpackage

// File: rtl/serial_read_buffer_edge_detector.sv
// Edge detector: turns the serial clock into single-cycle sample strobes and keeps data aligned.
// Define SERIAL_READ_BUFFER_SYNC_EN to insert synchronizers on both serial inputs.
`timescale 1ns/1ps
module edge_detector
   import serial_read_buffer_pkg::*;
#(
   parameter int unsigned FALL_EDGE = 0
) (
   input  logic i_sys_clk,
   input  logic i_rst,
   input  logic i_sig,
   input  logic i_data,
   output logic o_edge_sig,
   output logic o_data
);

   logic w_sig;
   logic w_data;
   logic r_hist;

`ifdef SERIAL_READ_BUFFER_SYNC_EN
   logic [SYNC_STAGES-1:0] r_sig_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;

   // Identical chains keep the sampled bit aligned with its strobe
   always_ff @(posedge i_sys_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sig_sync  <= '0;
         r_data_sync <= '0;
      end else begin
         r_sig_sync  <= {r_sig_sync[SYNC_STAGES-2:0], i_sig};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
      end
   end

   assign w_sig  = r_sig_sync[SYNC_STAGES-1];
   assign w_data = r_data_sync[SYNC_STAGES-1];
`else
   assign w_sig  = i_sig;
   assign w_data = i_data;
`endif

   always_ff @(posedge i_sys_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_hist <= 1'b0;
      end else begin
         r_hist <= w_sig;
      end
   end

   assign o_edge_sig = (FALL_EDGE != 0) ? (r_hist & ~w_sig) : (~r_hist & w_sig);
   assign o_data     = w_data;

endmodule

// File: rtl/serial_read_buffer.sv
// Serial-to-parallel capture: MSB-first serial stream into a BUF_SIZE-bit word.
// Synchronizers on the serial inputs are enabled with SERIAL_READ_BUFFER_SYNC_EN.
`timescale 1ns/1ps
module serial_read_buffer
   import serial_read_buffer_pkg::*;
#(
   parameter int unsigned BUF_SIZE  = 8,
   parameter int unsigned FALL_EDGE = 0
) (
   input  logic                i_sys_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_ser_clk,
   input  logic                i_data_in,
   output logic [BUF_SIZE-1:0] o_data_out,
   output logic                o_busy,
   output logic                o_data_ready
);

   localparam int unsigned CNT_W = $clog2(BUF_SIZE + 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [BUF_SIZE-1:0] r_shift;
   logic [BUF_SIZE-1:0] w_shift_nxt;
   logic [BUF_SIZE-1:0] w_shifted;
   logic [BUF_SIZE-1:0] r_data_out;
   logic [BUF_SIZE-1:0] w_data_out_nxt;
   logic                r_busy;
   logic                r_data_ready;
   logic                w_ready_nxt;
   logic                w_strobe;
   logic                w_bit;

   edge_detector #(
      .FALL_EDGE (FALL_EDGE)
   ) u_edge (
      .i_sys_clk  (i_sys_clk),
      .i_rst      (i_rst),
      .i_sig      (i_ser_clk),
      .i_data     (i_data_in),
      .o_edge_sig (w_strobe),
      .o_data     (w_bit)
   );

   // Left shift with the new bit entering at the LSB
   assign w_shifted = BUF_SIZE'({r_shift, w_bit});

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_data_out_nxt = r_data_out;
      w_ready_nxt    = r_data_ready;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = READ;
               w_cnt_nxt   = '0;
               w_shift_nxt = '0;
               w_ready_nxt = 1'b0;
            end
         end
         READ: begin
            if (w_strobe) begin
               w_shift_nxt = w_shifted;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(BUF_SIZE - 1)) begin
                  w_data_out_nxt = w_shifted;
                  w_ready_nxt    = 1'b1;
                  w_state_nxt    = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_data_out   <= '0;
         r_busy       <= 1'b0;
         r_data_ready <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_data_out   <= w_data_out_nxt;
         r_busy       <= (w_state_nxt == READ);
         r_data_ready <= w_ready_nxt;
      end
   end

   assign o_data_out   = r_data_out;
   assign o_busy       = r_busy;
   assign o_data_ready = r_data_ready;

endmodule

// File: tb/tb_serial_read_buffer.sv
// Self-checking bench for serial_read_buffer: rising- and falling-edge instances, scoreboarded words.
`timescale 1ns/1ps
module tb_serial_read_buffer;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       ser    = 1'b0;
   logic       dat    = 1'b0;
   logic [7:0] dout0, dout1;
   logic       busy0, busy1, rdy0, rdy1;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      logic [7:0] word;
      int         mid;
   } vec_t;

   vec_t vecs[6];

   // 12 MHz system clock
   always #41.667 clk = ~clk;

   serial_read_buffer #(.BUF_SIZE(8), .FALL_EDGE(0)) u_dut_r (
      .i_sys_clk    (clk),
      .i_rst        (rst_n),
      .i_start      (start0),
      .i_ser_clk    (ser),
      .i_data_in    (dat),
      .o_data_out   (dout0),
      .o_busy       (busy0),
      .o_data_ready (rdy0)
   );

   serial_read_buffer #(.BUF_SIZE(8), .FALL_EDGE(1)) u_dut_f (
      .i_sys_clk    (clk),
      .i_rst        (rst_n),
      .i_start      (start1),
      .i_ser_clk    (ser),
      .i_data_in    (dat),
      .o_data_out   (dout1),
      .o_busy       (busy1),
      .o_data_ready (rdy1)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic get_busy(input bit fe);
      return fe ? busy1 : busy0;
   endfunction

   function automatic logic get_rdy(input bit fe);
      return fe ? rdy1 : rdy0;
   endfunction

   function automatic logic [7:0] get_dout(input bit fe);
      return fe ? dout1 : dout0;
   endfunction

   task automatic set_start(input bit fe, input logic v);
      if (fe) start1 = v;
      else    start0 = v;
   endtask

   // One-cycle start; busy must be up and data_ready down one cycle later
   task automatic pulse_start(input bit fe);
      @(negedge clk);
      set_start(fe, 1'b1);
      @(negedge clk);
      set_start(fe, 1'b0);
      check("start_busy", {7'd0, get_busy(fe)}, 8'd1);
      check("start_ready_drop", {7'd0, get_rdy(fe)}, 8'd0);
   endtask

   // Send nbits MSB first; data changes on the non-sampling edge, 4 cycles per phase
   task automatic send_bits(input bit fe, input logic [7:0] w, input int nbits, input int mid);
      for (int i = 0; i < nbits; i++) begin
         ser = fe ? 1'b1 : 1'b0;
         dat = w[7-i];
         if (i == mid) begin
            set_start(fe, 1'b1);
            cyc(1);
            set_start(fe, 1'b0);
            cyc(3);
         end else begin
            cyc(4);
         end
         check("busy_during", {7'd0, get_busy(fe)}, 8'd1);
         ser = fe ? 1'b0 : 1'b1;
         cyc(4);
      end
   endtask

   // Bounded wait for completion, then pop the scoreboard and compare
   task automatic finish_word(input bit fe, input string name);
      logic [7:0] exp;
      int t = 0;
      while (get_rdy(fe) !== 1'b1 && t < 12) begin
         cyc(1);
         t++;
      end
      check({name, "_ready"}, {7'd0, get_rdy(fe)}, 8'd1);
      check({name, "_busy_low"}, {7'd0, get_busy(fe)}, 8'd0);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got 0x%02h", name, get_dout(fe));
      end else begin
         exp = sb_q.pop_front();
         check({name, "_data"}, get_dout(fe), exp);
      end
   endtask

   initial begin
      vecs[0] = '{8'h3A, -1};
      vecs[1] = '{8'h71, -1};
      vecs[2] = '{8'hF0, -1};
      vecs[3] = '{8'h3A,  3};
      vecs[4] = '{8'h00, -1};
      vecs[5] = '{8'hFF, -1};

      cyc(3);
      check("rst_dout_r", dout0, 8'h00);
      check("rst_busy_r", {7'd0, busy0}, 8'd0);
      check("rst_rdy_r",  {7'd0, rdy0},  8'd0);
      check("rst_dout_f", dout1, 8'h00);
      check("rst_busy_f", {7'd0, busy1}, 8'd0);
      check("rst_rdy_f",  {7'd0, rdy1},  8'd0);
      rst_n = 1'b1;
      cyc(2);

      // Serial clock toggling with no start must leave both instances untouched
      for (int i = 0; i < 8; i++) begin
         dat = i[0];
         ser = 1'b0;
         cyc(4);
         ser = 1'b1;
         cyc(4);
      end
      cyc(6);
      check("nostart_dout", dout0, 8'h00);
      check("nostart_busy", {7'd0, busy0}, 8'd0);
      check("nostart_rdy",  {7'd0, rdy0},  8'd0);
      check("nostart_dout_f", dout1, 8'h00);

      // Back-to-back words, including a start pulse mid-capture
      for (int v = 0; v < 6; v++) begin
         pulse_start(1'b0);
         sb_q.push_back(vecs[v].word);
         send_bits(1'b0, vecs[v].word, 8, vecs[v].mid);
         finish_word(1'b0, $sformatf("vec%0d", v));
      end

      // Reset mid-word discards the partial word and clears outputs at once
      pulse_start(1'b0);
      send_bits(1'b0, 8'h71, 4, -1);
      cyc(1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {7'd0, busy0}, 8'd0);
      check("midrst_rdy",  {7'd0, rdy0},  8'd0);
      check("midrst_dout", dout0, 8'h00);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      pulse_start(1'b0);
      sb_q.push_back(8'hF0);
      send_bits(1'b0, 8'hF0, 8, -1);
      finish_word(1'b0, "after_rst");

      // Falling-edge instance: data set on rising edge, sampled on falling
      ser = 1'b0;
      cyc(4);
      pulse_start(1'b1);
      sb_q.push_back(8'hA5);
      send_bits(1'b1, 8'hA5, 8, -1);
      finish_word(1'b1, "fall_edge");
      check("idle_r_dout_kept", dout0, 8'hF0);
      check("idle_r_rdy_kept", {7'd0, rdy0}, 8'd1);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_leftover: %0d words never completed", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
